// File: rtl/nibble_packetizer.sv
// Packs 4-bit nibbles into 16-bit words and frames them into packets bounded
// by MAXWORDS, an idle timeout, or a new upstream header.
module nibble_packetizer #(
    parameter int MAXWORDS = 64,
    parameter int TIMEOUT  = 255
) (
    input  logic        clk80,
    input  logic        reset,
    input  logic [3:0]  din,
    input  logic        davail,
    input  logic        header,
    output logic        realign_start,
    output logic [15:0] dout,
    output logic        dout_valid,
    output logic        dout_sop,
    output logic        dout_eop,
    output logic        dout_trunc
);

    typedef enum logic {IDLE, COLLECT} state_t;

    localparam logic [7:0] MAX_L     = 8'(MAXWORDS);
    localparam logic [7:0] TIMEOUT_L = 8'(TIMEOUT);

    state_t      state, state_n;
    logic [1:0]  nc, nc_n;
    logic [7:0]  wc, wc_n;
    logic [7:0]  tc, tc_n;
    logic [11:0] sr, sr_n;
    logic        first, first_n;
    logic        arm, arm_n;
    logic [15:0] dout_n;
    logic        valid_n, sop_n, eop_n, trunc_n, realign_n;
    logic [15:0] partial;
    logic [7:0]  wc_inc;

    // Partial word on forced termination: collected nibbles left-aligned, rest zero.
    always_comb begin
        partial = 16'h0000;
        case (nc)
            2'd1:    partial = {sr[3:0], 12'h000};
            2'd2:    partial = {sr[7:0], 8'h00};
            2'd3:    partial = {sr, 4'h0};
            default: partial = 16'h0000;
        endcase
    end

    assign wc_inc = wc + 8'd1;

    always_comb begin
        state_n   = state;
        nc_n      = nc;
        wc_n      = wc;
        tc_n      = tc;
        sr_n      = sr;
        first_n   = first;
        arm_n     = 1'b0;
        dout_n    = dout;
        valid_n   = 1'b0;
        sop_n     = 1'b0;
        eop_n     = 1'b0;
        trunc_n   = 1'b0;
        realign_n = arm;

        case (state)
            IDLE: begin
                if (header) begin
                    state_n = COLLECT;
                    nc_n    = 2'd0;
                    wc_n    = 8'd0;
                    tc_n    = 8'd0;
                    first_n = 1'b1;
                end
            end
            COLLECT: begin
                // A header outranks the timeout, and both outrank a nibble.
                if (header || tc == TIMEOUT_L) begin
                    valid_n = 1'b1;
                    dout_n  = partial;
                    sop_n   = first;
                    eop_n   = 1'b1;
                    trunc_n = 1'b1;
                    nc_n    = 2'd0;
                    wc_n    = 8'd0;
                    tc_n    = 8'd0;
                    if (header) begin
                        first_n = 1'b1;
                    end else begin
                        state_n   = IDLE;
                        realign_n = 1'b1;
                    end
                end else if (davail) begin
                    tc_n = 8'd0;
                    if (nc == 2'd3) begin
                        valid_n = 1'b1;
                        dout_n  = {sr, din};
                        sop_n   = first;
                        first_n = 1'b0;
                        nc_n    = 2'd0;
                        wc_n    = wc_inc;
                        if (wc_inc == MAX_L) begin
                            eop_n     = 1'b1;
                            state_n   = IDLE;
                            realign_n = 1'b1;
                            wc_n      = 8'd0;
                        end
                    end else begin
                        sr_n = {sr[7:0], din};
                        nc_n = nc + 2'd1;
                    end
                end else begin
                    tc_n = tc + 8'd1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // arm is set while in reset so realign_start fires on the first edge after release.
    always_ff @(posedge clk80 or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            nc            <= 2'd0;
            wc            <= 8'd0;
            tc            <= 8'd0;
            sr            <= 12'h000;
            first         <= 1'b0;
            arm           <= 1'b1;
            dout          <= 16'h0000;
            dout_valid    <= 1'b0;
            dout_sop      <= 1'b0;
            dout_eop      <= 1'b0;
            dout_trunc    <= 1'b0;
            realign_start <= 1'b0;
        end else begin
            state         <= state_n;
            nc            <= nc_n;
            wc            <= wc_n;
            tc            <= tc_n;
            sr            <= sr_n;
            first         <= first_n;
            arm           <= arm_n;
            dout          <= dout_n;
            dout_valid    <= valid_n;
            dout_sop      <= sop_n;
            dout_eop      <= eop_n;
            dout_trunc    <= trunc_n;
            realign_start <= realign_n;
        end
    end

endmodule
